// File: rtl/debounce_sync_if.sv
// Raw-input conditioner bundle: raw level and enable in,
// debounced level, edge pulses, toggle and busy out.
interface debounce_sync_if;
  logic raw_in;
  logic enable;
  logic clean;
  logic rise;
  logic fall;
  logic toggle;
  logic busy;

  modport master (
    output raw_in,
    output enable,
    input  clean,
    input  rise,
    input  fall,
    input  toggle,
    input  busy
  );

  modport slave (
    input  raw_in,
    input  enable,
    output clean,
    output rise,
    output fall,
    output toggle,
    output busy
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronise a raw asynchronous input, reject bounce shorter than
// DEBOUNCE_CYCLES and emit clean level, edge pulses and toggle.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input logic            clk,
  input logic            reset,
  debounce_sync_if.slave bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end

  if (DEBOUNCE_CYCLES < 2 ||
      (64'(DEBOUNCE_CYCLES) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt
    $error("debounce_sync: DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             clean_q, clean_n;
  logic             rise_q, rise_n;
  logic             fall_q, fall_n;
  logic             toggle_q, toggle_n;
  logic             busy_q, busy_n;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, free-running regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
    end
  end

  // Next state, counter and registered outputs; enable=0 aborts waits.
  always_comb begin
    state_n  = state_q;
    cnt_n    = '0;
    clean_n  = clean_q;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    toggle_n = toggle_q;
    unique case (state_q)
      IDLE_LO: begin
        if (s && bus.enable) begin
          state_n = WAIT_HI;
          cnt_n   = ONE;
        end
      end
      WAIT_HI: begin
        if (!bus.enable || !s) begin
          state_n = IDLE_LO;
        end else if (cnt_q == LAST) begin
          state_n  = IDLE_HI;
          clean_n  = 1'b1;
          rise_n   = 1'b1;
          toggle_n = ~toggle_q;
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      IDLE_HI: begin
        if (!s && bus.enable) begin
          state_n = WAIT_LO;
          cnt_n   = ONE;
        end
      end
      WAIT_LO: begin
        if (!bus.enable || s) begin
          state_n = IDLE_HI;
        end else if (cnt_q == LAST) begin
          state_n = IDLE_LO;
          clean_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      default: begin
        state_n = IDLE_LO;
      end
    endcase
    busy_n = (state_n == WAIT_HI) || (state_n == WAIT_LO);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      clean_q  <= clean_n;
      rise_q   <= rise_n;
      fall_q   <= fall_n;
      toggle_q <= toggle_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.clean  = clean_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.toggle = toggle_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Randomised and directed bench for debounce_sync against a
// run-length reference model of the debounce rules.
module tb_debounce_sync;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  debounce_sync_if bus ();

  debounce_sync #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  logic [SS-1:0] m_dly;
  int   m_run;
  logic m_clean, m_toggle, m_rise, m_fall;
  int   d_rise = 0;
  int   d_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_dly = '0;
    m_run = 0;
    m_clean = 1'b0;
    m_toggle = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  // A new level is accepted after DC consecutive enabled samples
  // of the synchronised input that differ from the accepted level.
  task automatic m_edge(input logic raw, input logic en);
    logic s;
    s = m_dly[SS-1];
    m_dly = {m_dly[SS-2:0], raw};
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (en && (s != m_clean)) m_run++;
    else m_run = 0;
    if (m_run == DC) begin
      m_run = 0;
      m_clean = ~m_clean;
      if (m_clean) begin
        m_rise = 1'b1;
        m_toggle = ~m_toggle;
      end else begin
        m_fall = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("clean", bus.clean, m_clean);
    check("rise", bus.rise, m_rise);
    check("fall", bus.fall, m_fall);
    check("toggle", bus.toggle, m_toggle);
    check("busy", bus.busy, m_run != 0);
    check("excl", bus.rise & bus.fall, 1'b0);
    d_rise += int'(bus.rise);
    d_fall += int'(bus.fall);
  endtask

  task automatic step(input logic raw, input logic en);
    bus.raw_in = raw;
    bus.enable = en;
    @(posedge clk);
    m_edge(raw, en);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b0;
    m_reset();
    #1;
    compare_all();
    #2;
    reset = 1'b1;
  endtask

  logic [8:0] bounce;
  int r0, f0;
  logic rr, ee;

  initial begin
    bus.raw_in = 1'b0;
    bus.enable = 1'b1;
    m_reset();
    #12;
    compare_all();
    reset = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1);
      if (i == 2) check("busy_e2", bus.busy, 1'b0);
      if (i == 5) check("busy_e5", bus.busy, 1'b1);
      if (i == 6) check("rise_e6", bus.rise, 1'b1);
      if (i == 7) check("rise_e7", bus.rise, 1'b0);
    end
    check("toggle_1", bus.toggle, 1'b1);

    f0 = d_fall;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("glitch_nofall", d_fall - f0, 0);
    check("glitch_clean", bus.clean, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    r0 = d_rise;
    f0 = d_fall;
    bounce = 9'b101101111;
    for (int i = 8; i >= 0; i--) step(bounce[i], 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("bounce_rise", d_rise - r0, 1);
    check("bounce_nofall", d_fall - f0, 0);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    r0 = d_rise;
    f0 = d_fall;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    end
    check("press_rise", d_rise - r0, 2);
    check("press_fall", d_fall - f0, 2);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("en_busy_pre", bus.busy, 1'b1);
    step(1'b1, 1'b0);
    check("en_busy_drop", bus.busy, 1'b0);
    check("en_clean", bus.clean, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1);
      if (i == 3) check("reen_rise_e3", bus.rise, 1'b0);
      if (i == 4) check("reen_rise_e4", bus.rise, 1'b1);
    end

    step(1'b1, 1'b1);
    f0 = d_fall;
    async_reset();
    check("rst_clean", bus.clean, 1'b0);
    check("rst_toggle", bus.toggle, 1'b0);
    check("rst_nofall", d_fall - f0, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1);
      if (i == 5) check("rst_rise_e5", bus.rise, 1'b0);
      if (i == 6) check("rst_rise_e6", bus.rise, 1'b1);
    end

    rr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rr = ~rr;
      ee = ($urandom_range(19) != 0);
      if ($urandom_range(399) == 0) async_reset();
      step(rr, ee);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
